// File: rtl/bcedn_stream_probe.sv
// Selectable-tap capture buffer for BCEDN inter-layer streams, one-shot or ring.
// Define BCEDN_PROBE_TSTAMP_EN to prefix each entry with a cycles-since-arm stamp.
module bcedn_stream_probe #(
  parameter int NUM_CH     = 12,
  parameter int DATA_WIDTH = 24,
  parameter int DEPTH      = 1024,
  parameter int CNT_WIDTH  = 32,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AW   = $clog2(DEPTH),
`ifdef BCEDN_PROBE_TSTAMP_EN
  localparam int RW   = CNT_WIDTH + DATA_WIDTH
`else
  localparam int RW   = DATA_WIDTH
`endif
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0] tap_data,
  input  logic [NUM_CH-1:0]            tap_en,
  input  logic [CH_W-1:0]              cfg_ch,
  input  logic                         cfg_ring,
  input  logic                         arm,
  input  logic                         stop,
  input  logic                         rd_en,
  output logic [RW-1:0]                rd_data,
  output logic                         rd_valid,
  output logic                         rd_empty,
  output logic                         capturing,
  output logic                         done,
  output logic                         overflow,
  output logic [CNT_WIDTH-1:0]         beat_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CAP  = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;

  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [1:0]            state;
  logic [CH_W-1:0]       ch_q;
  logic [CH_W-1:0]       ch_new;
  logic                  ring_q;
  logic [AW-1:0]         wr_ptr;
  logic [AW:0]           fill;
  logic [AW:0]           rd_idx;
  logic [AW-1:0]         rd_addr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [RW-1:0]         wr_word;
  logic                  sel_en;
  logic                  wr_fire;
  logic                  last_wr;
  logic                  rd_fire;
  logic                  rd_last;
  logic                  cnt_en;

  logic [RW-1:0] mem [DEPTH];

  assign ch_new   = (int'(cfg_ch) >= NUM_CH) ? '0 : cfg_ch;
  assign sel_data = tap_data[ch_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_en   = tap_en[ch_q];

  assign capturing = (state == S_CAP);
  assign done      = (state == S_RD);
  assign rd_empty  = !(done && (rd_idx != fill));

  // arm pre-empts everything, including the beat in its own cycle
  assign wr_fire = capturing && sel_en && !arm;
  assign last_wr = wr_fire && !ring_q && (fill == FULL - ONE);
  assign rd_fire = done && rd_en && !rd_empty && !arm;
  assign rd_last = rd_fire && (rd_idx + ONE == fill);
  assign cnt_en  = sel_en && (capturing || (done && !ring_q));

  // oldest entry sits at the write pointer once the ring has lapped
  assign rd_addr = (overflow ? wr_ptr : '0) + rd_idx[AW-1:0];

`ifdef BCEDN_PROBE_TSTAMP_EN
  logic [CNT_WIDTH-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst || arm) ts_q <= '0;
    else            ts_q <= ts_q + 1'b1;
  end

  assign wr_word = {ts_q + 1'b1, sel_data};
`else
  assign wr_word = sel_data;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else if (arm) begin
      state <= S_CAP;
    end else begin
      case (state)
        S_CAP: if (last_wr || (ring_q && stop)) state <= S_RD;
        S_RD:  if (rd_empty || rd_last) state <= S_IDLE;
        default: state <= state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q     <= '0;
      ring_q   <= 1'b0;
      wr_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
      beat_cnt <= '0;
      rd_idx   <= '0;
    end else if (arm) begin
      ch_q     <= ch_new;
      ring_q   <= cfg_ring;
      wr_ptr   <= '0;
      fill     <= '0;
      overflow <= 1'b0;
      beat_cnt <= '0;
      rd_idx   <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != FULL) fill <= fill + ONE;
        if (wr_ptr == '0 && fill == FULL) overflow <= 1'b1;
      end
      if (cnt_en && beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
      if (rd_fire) rd_idx <= rd_idx + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !rst) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= rd_fire;
      if (rd_fire) rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_bcedn_stream_probe.sv
// Bench for bcedn_stream_probe: random traffic against a queue-based capture model.
// Honours BCEDN_PROBE_TSTAMP_EN for the timestamp scenario.
module tb_bcedn_stream_probe;

  localparam int NC = 12;
  localparam int DW = 24;
  localparam int DP = 16;
  localparam int CW = 32;
`ifdef BCEDN_PROBE_TSTAMP_EN
  localparam int RW = CW + DW;
`else
  localparam int RW = DW;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [NC*DW-1:0] tap_data;
  logic [NC-1:0]   tap_en;
  logic [3:0]      cfg_ch;
  logic            cfg_ring;
  logic            arm;
  logic            stop;
  logic            rd_en;
  logic [RW-1:0]   rd_data;
  logic            rd_valid;
  logic            rd_empty;
  logic            capturing;
  logic            done;
  logic            overflow;
  logic [CW-1:0]   beat_cnt;

  bcedn_stream_probe #(
    .NUM_CH(NC), .DATA_WIDTH(DW), .DEPTH(DP), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .tap_data(tap_data), .tap_en(tap_en),
    .cfg_ch(cfg_ch), .cfg_ring(cfg_ring),
    .arm(arm), .stop(stop), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty),
    .capturing(capturing), .done(done), .overflow(overflow),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  bit exp_ovf;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input int ch, input bit ring);
    tap_en = '0;
    cfg_ch = 4'(ch);
    cfg_ring = ring;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    sent_q.delete();
  endtask

  // one cycle of traffic: noise on other taps, optional beat on ch
  task automatic send_cycle(input int ch, input bit beat, input logic [DW-1:0] d);
    tap_en = NC'($urandom);
    tap_en[ch] = beat;
    for (int k = 0; k < NC; k++) tap_data[k*DW +: DW] = DW'($urandom);
    tap_data[ch*DW +: DW] = d;
    if (beat) sent_q.push_back(d);
    tick();
    tap_en = '0;
  endtask

  task automatic gap(input int ch);
    repeat ($urandom_range(0, 2)) send_cycle(ch, 1'b0, '0);
  endtask

  // what a capture buffer of DP entries must hold after the sent beats
  task automatic build_model(input bit ring);
    int n;
    int lo;
    int hi;
    n = sent_q.size();
    exp_q.delete();
    lo = (ring && n > DP) ? n - DP : 0;
    hi = (!ring && n > DP) ? DP : n;
    for (int i = lo; i < hi; i++) exp_q.push_back(sent_q[i]);
    exp_ovf = ring && (n > DP);
  endtask

  task automatic drain;
    got_q.delete();
    for (int i = 0; i < 4*DP + 8; i++) begin
      rd_en = !rd_empty && ($urandom_range(0, 3) != 0);
      tick();
      if (rd_valid) got_q.push_back(rd_data);
      if (rd_empty && !rd_valid) break;
    end
    rd_en = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({capturing, done, rd_empty, overflow, rd_valid} !== 5'b00100)
      $display("FAIL reset_flags: got %b want 00100",
               {capturing, done, rd_empty, overflow, rd_valid});
    else n_pass++;
    n_checks++;
    if (beat_cnt !== '0 || rd_data !== '0)
      $display("FAIL reset_regs: beat_cnt %h rd_data %h want 0", beat_cnt, rd_data);
    else n_pass++;
    rst = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    n_checks++;
    if (rd_valid !== 1'b0) $display("FAIL idle_read: rd_valid %b want 0", rd_valid);
    else n_pass++;
  endtask

  task automatic test_oneshot;
    do_arm(3, 1'b0);
    for (int v = 1; v <= 20; v++) begin
      gap(3);
      if (v == 8) begin
        stop = 1'b1;
        send_cycle(3, 1'b0, '0);
        stop = 1'b0;
        n_checks++;
        if (capturing !== 1'b1) $display("FAIL oneshot_stop_ignored: capturing %b want 1", capturing);
        else n_pass++;
      end
      send_cycle(3, 1'b1, DW'(v));
      if (v == 15) begin
        n_checks++;
        if (done !== 1'b0) $display("FAIL oneshot_early: done %b want 0", done);
        else n_pass++;
      end
      if (v == 16) begin
        n_checks++;
        if ({capturing, done} !== 2'b01)
          $display("FAIL oneshot_full: cap/done %b want 01", {capturing, done});
        else n_pass++;
      end
    end
    build_model(1'b0);
    n_checks++;
    if (beat_cnt !== CW'(20) || overflow !== 1'b0)
      $display("FAIL oneshot_cnt: beat_cnt %0d ovf %b want 20 0", beat_cnt, overflow);
    else n_pass++;
    drain();
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL oneshot_size: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i][DW-1:0] !== exp_q[i])
        $display("FAIL oneshot_pop[%0d]: got %h want %h", i,
                 (i < got_q.size()) ? got_q[i][DW-1:0] : 'x, exp_q[i]);
      else n_pass++;
    end
    n_checks++;
    if ({rd_empty, done, capturing} !== 3'b100)
      $display("FAIL oneshot_end: empty/done/cap %b want 100", {rd_empty, done, capturing});
    else n_pass++;
  endtask

  task automatic test_ring_wrap;
    do_arm(11, 1'b1);
    for (int v = 1; v <= 40; v++) begin
      gap(11);
      send_cycle(11, 1'b1, DW'(v));
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    build_model(1'b1);
    n_checks++;
    if ({done, overflow} !== 2'b11 || beat_cnt !== CW'(40))
      $display("FAIL ring_wrap_state: done %b ovf %b cnt %0d want 1 1 40",
               done, overflow, beat_cnt);
    else n_pass++;
    drain();
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL ring_wrap_size: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i][DW-1:0] !== exp_q[i])
        $display("FAIL ring_wrap_pop[%0d]: got %h want %h", i,
                 (i < got_q.size()) ? got_q[i][DW-1:0] : 'x, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_ring_stop_same;
    do_arm(6, 1'b1);
    for (int v = 1; v <= 5; v++) begin
      gap(6);
      stop = (v == 5);
      send_cycle(6, 1'b1, DW'(v));
      stop = 1'b0;
    end
    build_model(1'b1);
    n_checks++;
    if ({done, overflow} !== 2'b10 || beat_cnt !== CW'(5))
      $display("FAIL stop_same_state: done %b ovf %b cnt %0d want 1 0 5",
               done, overflow, beat_cnt);
    else n_pass++;
    drain();
    n_checks++;
    if (got_q.size() != 5) $display("FAIL stop_same_size: got %0d want 5", got_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i][DW-1:0] !== exp_q[i])
        $display("FAIL stop_same_pop[%0d]: got %h want %h", i,
                 (i < got_q.size()) ? got_q[i][DW-1:0] : 'x, exp_q[i]);
      else n_pass++;
    end
    // stop with nothing written: readout is empty and falls straight to idle
    do_arm(2, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    n_checks++;
    if ({done, rd_empty} !== 2'b11)
      $display("FAIL empty_stop: done/empty %b want 11", {done, rd_empty});
    else n_pass++;
    tick();
    n_checks++;
    if ({done, capturing} !== 2'b00)
      $display("FAIL empty_idle: done/cap %b want 00", {done, capturing});
    else n_pass++;
  endtask

  task automatic test_channel_isolation;
    do_arm(7, 1'b0);
    for (int s = 0; s < DP; s++) begin
      for (int k = 0; k < NC; k++) tap_data[k*DW +: DW] = DW'((k << 16) | s);
      tap_en = '1;
      sent_q.push_back(DW'((7 << 16) | s));
      tick();
    end
    tap_en = '0;
    build_model(1'b0);
    drain();
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL iso_size: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i][DW-1:0] !== exp_q[i])
        $display("FAIL iso_pop[%0d]: got %h want %h", i,
                 (i < got_q.size()) ? got_q[i][DW-1:0] : 'x, exp_q[i]);
      else n_pass++;
    end
    // out-of-range select falls back to tap 0
    do_arm(15, 1'b1);
    for (int s = 0; s < 6; s++) begin
      for (int k = 0; k < NC; k++) tap_data[k*DW +: DW] = DW'((k << 16) | (s + 'h100));
      tap_en = '1;
      sent_q.push_back(DW'(s + 'h100));
      tick();
    end
    tap_en = '0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    build_model(1'b1);
    drain();
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL badch_size: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i][DW-1:0] !== exp_q[i])
        $display("FAIL badch_pop[%0d]: got %h want %h", i,
                 (i < got_q.size()) ? got_q[i][DW-1:0] : 'x, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rst_mid;
    do_arm(2, 1'b1);
    for (int v = 1; v <= 8; v++) send_cycle(2, 1'b1, DW'(v + 'h50));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if ({capturing, done, rd_empty} !== 3'b001 || beat_cnt !== '0)
      $display("FAIL rst_mid: cap/done/empty %b cnt %0d want 001 0",
               {capturing, done, rd_empty}, beat_cnt);
    else n_pass++;
    do_arm(2, 1'b0);
    for (int v = 1; v <= DP; v++) begin
      gap(2);
      send_cycle(2, 1'b1, DW'($urandom));
    end
    build_model(1'b0);
    drain();
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL rst_rearm_size: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i][DW-1:0] !== exp_q[i])
        $display("FAIL rst_rearm_pop[%0d]: got %h want %h", i,
                 (i < got_q.size()) ? got_q[i][DW-1:0] : 'x, exp_q[i]);
      else n_pass++;
    end
  endtask

  task automatic test_rearm;
    do_arm(4, 1'b1);
    for (int v = 1; v <= 5; v++) send_cycle(4, 1'b1, DW'(v + 'h70));
    // re-arm mid-capture with a beat on the new tap in the arm cycle
    cfg_ch = 4'd9;
    cfg_ring = 1'b0;
    arm = 1'b1;
    tap_en = '0;
    tap_en[9] = 1'b1;
    tap_data[9*DW +: DW] = 24'habcdef;
    tick();
    arm = 1'b0;
    tap_en = '0;
    sent_q.delete();
    n_checks++;
    if (capturing !== 1'b1 || beat_cnt !== '0 || overflow !== 1'b0)
      $display("FAIL rearm_state: cap %b cnt %0d ovf %b want 1 0 0",
               capturing, beat_cnt, overflow);
    else n_pass++;
    for (int v = 1; v <= DP; v++) send_cycle(9, 1'b1, DW'($urandom));
    build_model(1'b0);
    drain();
    n_checks++;
    if (got_q.size() != exp_q.size())
      $display("FAIL rearm_size: got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    foreach (exp_q[i]) begin
      n_checks++;
      if (i >= got_q.size() || got_q[i][DW-1:0] !== exp_q[i])
        $display("FAIL rearm_pop[%0d]: got %h want %h", i,
                 (i < got_q.size()) ? got_q[i][DW-1:0] : 'x, exp_q[i]);
      else n_pass++;
    end
  endtask

`ifdef BCEDN_PROBE_TSTAMP_EN
  task automatic test_tstamp;
    do_arm(1, 1'b1);
    tick();
    tick();
    send_cycle(1, 1'b1, 24'h00aaaa);
    tick();
    tick();
    tick();
    send_cycle(1, 1'b1, 24'h00bbbb);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    drain();
    n_checks++;
    if (got_q.size() != 2) $display("FAIL tstamp_size: got %0d want 2", got_q.size());
    else n_pass++;
    n_checks++;
    if (got_q.size() < 1 || got_q[0] !== {CW'(3), 24'h00aaaa})
      $display("FAIL tstamp_first: got %h want %h",
               (got_q.size() > 0) ? got_q[0] : 'x, {CW'(3), 24'h00aaaa});
    else n_pass++;
    n_checks++;
    if (got_q.size() < 2 || got_q[1] !== {CW'(7), 24'h00bbbb})
      $display("FAIL tstamp_second: got %h want %h",
               (got_q.size() > 1) ? got_q[1] : 'x, {CW'(7), 24'h00bbbb});
    else n_pass++;
  endtask
`endif

  task automatic test_random;
    for (int it = 0; it < 8; it++) begin
      bit ring;
      bit same;
      int ch;
      int eff;
      int n;
      ring = 1'($urandom);
      same = 1'($urandom);
      ch = $urandom_range(0, 15);
      eff = (ch >= NC) ? 0 : ch;
      n = ring ? $urandom_range(1, 3*DP) : $urandom_range(DP, DP + 8);
      do_arm(ch, ring);
      for (int v = 1; v <= n; v++) begin
        gap(eff);
        stop = ring && same && (v == n);
        send_cycle(eff, 1'b1, DW'($urandom));
        stop = 1'b0;
      end
      if (ring && !same) begin
        stop = 1'b1;
        tick();
        stop = 1'b0;
      end
      build_model(ring);
      n_checks++;
      if (done !== 1'b1 || overflow !== exp_ovf || beat_cnt !== CW'(n))
        $display("FAIL rand%0d_state: done %b ovf %b cnt %0d want 1 %b %0d",
                 it, done, overflow, beat_cnt, exp_ovf, n);
      else n_pass++;
      drain();
      n_checks++;
      if (got_q.size() != exp_q.size())
        $display("FAIL rand%0d_size: got %0d want %0d", it, got_q.size(), exp_q.size());
      else n_pass++;
      foreach (exp_q[i]) begin
        n_checks++;
        if (i >= got_q.size() || got_q[i][DW-1:0] !== exp_q[i])
          $display("FAIL rand%0d_pop[%0d]: got %h want %h", it, i,
                   (i < got_q.size()) ? got_q[i][DW-1:0] : 'x, exp_q[i]);
        else n_pass++;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    tap_data = '0;
    tap_en = '0;
    cfg_ch = '0;
    cfg_ring = 1'b0;
    arm = 1'b0;
    stop = 1'b0;
    rd_en = 1'b0;
    test_reset();
    test_oneshot();
    test_ring_wrap();
    test_ring_stop_same();
    test_channel_isolation();
    test_rst_mid();
    test_rearm();
`ifdef BCEDN_PROBE_TSTAMP_EN
    test_tstamp();
`endif
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bcedn_stream_probe.md
Name: bcedn_stream_probe

Overview:
- Parametrised on-chip capture buffer for the valid-qualified streams between BCEDN layers (AD, EC1..EC3, EDC4-5, DC6..DC10, output).
- Selects one of NUM_CH tap streams and captures its beats into a DEPTH-entry buffer, in one-shot or ring mode.
- Buffer is read back in arrival order after capture ends.
- Replaces simulation-only hierarchical dumping with a synthesizable probe usable in gate-level and silicon bring-up.

Parameters:
NUM_CH, 12, number of tap streams
DATA_WIDTH, 24, width of each tap beat (narrower layers zero-extended at the instantiation site)
DEPTH, 1024, capture entries; power of two, >= 4
CNT_WIDTH, 32, width of beat counter and timestamp

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
tap_data  in  NUM_CH*DATA_WIDTH  concatenated tap beats, channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
tap_en  in  NUM_CH  per-channel beat valid
cfg_ch  in  $clog2(NUM_CH)  selected channel; sampled on arm
cfg_ring  in  1  0 = one-shot, 1 = ring; sampled on arm
arm  in  1  start-capture pulse
stop  in  1  end-capture pulse; ring mode only
rd_en  in  1  pop request
rd_data  out  DATA_WIDTH (+CNT_WIDTH with option)  popped entry
rd_valid  out  1  rd_data valid, one cycle
rd_empty  out  1  no unread entries
capturing  out  1  state == CAPTURE
done  out  1  state == READOUT
overflow  out  1  ring wrapped at least once; sticky until next arm
beat_cnt  out  CNT_WIDTH  selected-channel beats seen since arm; saturates

Behaviour:
- States and transitions:
  - IDLE -> CAPTURE on arm.
  - CAPTURE -> READOUT when one-shot fills DEPTH entries, or on stop in ring mode.
  - READOUT -> IDLE after the last entry pops. arm in READOUT also goes to CAPTURE, discarding unread data.
  - arm in CAPTURE restarts capture: pointers, count and overflow cleared; cfg re-sampled.
- Reset: state IDLE, all pointers 0, rd_data 0, rd_valid 0, rd_empty 1, capturing 0, done 0, overflow 0, beat_cnt 0. Buffer contents are not reset.
- Mid-capture rst aborts to IDLE; no partial readout.
- Channel decode:
  - cfg_ch latched on arm.
  - cfg_ch >= NUM_CH latches channel 0.
  - Write occurs when state == CAPTURE and tap_en[ch]. Beat in the arm cycle is not captured.
- One-shot mode:
  - Write pointer advances 0..DEPTH-1.
  - On the DEPTH-th write, state -> READOUT next cycle. Later beats are counted in beat_cnt but not stored.
- Ring mode:
  - Write pointer wraps DEPTH-1 -> 0.
  - overflow is set in the cycle after the first write that lands on index 0 post-wrap.
  - stop with a simultaneous beat: the beat is stored, then state -> READOUT.
  - stop in one-shot mode is ignored.
- Readout order and count:
  - Oldest first. Start index = write pointer if overflow, else 0.
  - Entry count = min(total writes, DEPTH). Track with a fill counter of $clog2(DEPTH)+1 bits.
  - stop with zero writes -> READOUT with rd_empty=1 -> IDLE next cycle.
- Read timing:
  - rd_en in READOUT with !rd_empty: rd_data/rd_valid appear 1 cycle later (synchronous RAM read). Back-to-back rd_en gives one entry per cycle.
  - rd_en when empty or outside READOUT: ignored, rd_valid=0.
  - rd_data holds its last value when rd_valid=0.
- beat_cnt: increments on every selected beat in CAPTURE (including post-full in one-shot); saturates at all-ones; cleared on arm.
- Simultaneous arm and stop: arm wins.

Optional Feature:
- Macro: BCEDN_PROBE_TSTAMP_EN.
- Defined:
  - A free-running CNT_WIDTH cycle counter is cleared on arm.
  - Each stored entry is {timestamp, data}; rd_data width = CNT_WIDTH+DATA_WIDTH, timestamp in the MSBs.
  - The timestamp of the first beat after arm equals the number of cycles since arm (arm cycle = 0).
- Undefined: no counter; rd_data width = DATA_WIDTH.

Test Plan:
- One-shot, DEPTH=16, ch=3, 20 beats 0x000001..0x000014 (gaps allowed) -> done after the 16th beat, beat_cnt=20, overflow=0, 16 pops return 0x01..0x10 in order, then rd_empty=1 and state IDLE.
- Ring, DEPTH=16, ch=11, 40 beats 1..40, then stop -> overflow=1, pops return 25..40.
- Ring, 5 beats, stop in the same cycle as the 5th beat -> 5 entries 1..5, overflow=0.
- Channel isolation: all channels active, ch=7, tap k carries k<<16|seq -> only 0x07xxxx captured; cfg_ch=15 with NUM_CH=12 captures channel 0.
- rst asserted mid-capture (after 8 beats) -> next cycle capturing=0, rd_empty=1, beat_cnt=0; re-arm captures from index 0.
- With BCEDN_PROBE_TSTAMP_EN: arm at cycle T, beats at T+3 and T+7 -> timestamps 3 and 7 in rd_data MSBs.
